// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer: bus responder with an 8-byte register window and an IRQ source.
// Optional wait-state stretching of bus accesses is built when BUS_TIMER_WAIT_EN is defined.
module bus_timer #(
  parameter logic [15:0] P_BASE = 16'hD000,
  parameter int unsigned P_WAIT = 0
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_addr,
  input  logic        I_rdwr,
  input  logic [7:0]  I_wr_data,
  output logic [7:0]  O_rd_data,
  output logic        O_sel,
  output logic        O_ready,
  output logic        O_irq
);

  localparam logic [2:0] LP_OFF_RLD_LO = 3'd0;
  localparam logic [2:0] LP_OFF_RLD_HI = 3'd1;
  localparam logic [2:0] LP_OFF_CNT_LO = 3'd2;
  localparam logic [2:0] LP_OFF_CNT_HI = 3'd3;
  localparam logic [2:0] LP_OFF_CTRL   = 3'd4;
  localparam logic [2:0] LP_OFF_STAT   = 3'd5;

  logic        r_last_phy2;
  logic [7:0]  r_rld_lo;
  logic [7:0]  r_rld_hi;
  logic [15:0] r_cnt;
  logic [7:0]  r_snap;
  logic        r_en;
  logic        r_irq_en;
  logic        r_oneshot;
  logic        r_expired;
  logic        r_irq;

  logic        w_pf;
  logic [2:0]  w_off;
  logic        w_done;
  logic        w_wr;
  logic        w_rd;
  logic        w_expire;
  logic        w_wr_rld_hi;
  logic        w_w1c;

  assign w_pf   = r_last_phy2 & ~I_phy2;
  assign O_sel  = (I_addr[15:3] == P_BASE[15:3]);
  assign w_off  = I_addr[2:0];
  assign w_done = w_pf & O_sel & O_ready;
  assign w_wr   = w_done & ~I_rdwr;
  assign w_rd   = w_done & I_rdwr;

  assign w_expire    = r_en & (r_cnt == 16'd0);
  assign w_wr_rld_hi = w_wr & (w_off == LP_OFF_RLD_HI);
  assign w_w1c       = w_wr & (w_off == LP_OFF_STAT) & I_wr_data[0];

`ifdef BUS_TIMER_WAIT_EN
  // state | meaning
  // IDLE  | r_wcnt == 0, no stretched phase-2 periods taken yet
  // WAIT  | r_wcnt != 0, access held off until r_wcnt reaches P_WAIT
  localparam logic [2:0] LP_WAIT = 3'(P_WAIT);

  logic [2:0] r_wcnt;

  assign O_ready = ~(O_sel & (r_wcnt != LP_WAIT));

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_wcnt <= 3'd0;
    end else if (w_pf) begin
      if (!O_sel || O_ready) begin
        r_wcnt <= 3'd0;
      end else begin
        r_wcnt <= r_wcnt + 3'd1;
      end
    end
  end
`else
  localparam logic [2:0] LP_WAIT_UNUSED = 3'(P_WAIT);

  assign O_ready = 1'b1;
`endif

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_last_phy2 <= 1'b0;
      r_rld_lo    <= 8'h00;
      r_rld_hi    <= 8'h00;
      r_cnt       <= 16'h0000;
      r_snap      <= 8'h00;
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_oneshot   <= 1'b0;
      r_expired   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_last_phy2 <= I_phy2;
      r_irq       <= r_expired & r_irq_en;

      if (w_pf) begin
        if (r_en) begin
          if (w_expire) begin
            r_cnt <= {r_rld_hi, r_rld_lo};
            if (r_oneshot) begin
              r_en <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        // Bus writes come after counting so that a same-edge write overrides it.
        if (w_wr) begin
          case (w_off)
            LP_OFF_RLD_LO: r_rld_lo <= I_wr_data;
            LP_OFF_RLD_HI: begin
              r_rld_hi <= I_wr_data;
              r_cnt    <= {I_wr_data, r_rld_lo};
            end
            LP_OFF_CTRL: begin
              r_en      <= I_wr_data[0];
              r_irq_en  <= I_wr_data[1];
              r_oneshot <= I_wr_data[2];
            end
            default: ;
          endcase
        end

        if (w_rd && (w_off == LP_OFF_CNT_LO)) begin
          r_snap <= r_cnt[15:8];
        end

        // EXPIRED priority: reload write clears, then expiry sets, then W1C clears.
        if (w_wr_rld_hi) begin
          r_expired <= 1'b0;
        end else if (w_expire) begin
          r_expired <= 1'b1;
        end else if (w_w1c) begin
          r_expired <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    O_rd_data = 8'h00;
    if (O_sel) begin
      case (w_off)
        LP_OFF_RLD_LO: O_rd_data = r_rld_lo;
        LP_OFF_RLD_HI: O_rd_data = r_rld_hi;
        LP_OFF_CNT_LO: O_rd_data = r_cnt[7:0];
        LP_OFF_CNT_HI: O_rd_data = r_snap;
        LP_OFF_CTRL:   O_rd_data = {5'b00000, r_oneshot, r_irq_en, r_en};
        LP_OFF_STAT:   O_rd_data = {7'b0000000, r_expired};
        default:       O_rd_data = 8'h00;
      endcase
    end
  end

  assign O_irq = r_irq;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed table, hand-written corner sequences and
// randomized bus traffic compared against a behavioural register/counter model.
module tb_bus_timer;

  localparam logic [15:0] LP_BASE = 16'hD000;
`ifdef BUS_TIMER_WAIT_EN
  localparam int LP_WAIT = 2;
`else
  localparam int LP_WAIT = 0;
`endif
  localparam logic [15:0] LP_IDLE = 16'h1234;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic        I_phy2;
  logic [15:0] I_addr;
  logic        I_rdwr;
  logic [7:0]  I_wr_data;
  logic [7:0]  O_rd_data;
  logic        O_sel;
  logic        O_ready;
  logic        O_irq;

  bus_timer #(.P_BASE(LP_BASE), .P_WAIT(2)) dut (
    .I_clock   (I_clock),
    .I_reset   (I_reset),
    .I_phy2    (I_phy2),
    .I_addr    (I_addr),
    .I_rdwr    (I_rdwr),
    .I_wr_data (I_wr_data),
    .O_rd_data (O_rd_data),
    .O_sel     (O_sel),
    .O_ready   (O_ready),
    .O_irq     (O_irq)
  );

  always #5 I_clock = ~I_clock;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [15:0] m_rld;
  logic [15:0] m_cnt;
  logic [7:0]  m_snap;
  logic        m_en;
  logic        m_irq_en;
  logic        m_oneshot;
  logic        m_exp;
  int          m_pend;

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  wdata;
    logic        chk;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rld = 16'h0; m_cnt = 16'h0; m_snap = 8'h0;
    m_en = 1'b0; m_irq_en = 1'b0; m_oneshot = 1'b0; m_exp = 1'b0;
    m_pend = 0;
  endtask

  function automatic logic m_sel(input logic [15:0] a);
    return a[15:3] == LP_BASE[15:3];
  endfunction

  function automatic logic [7:0] m_rd(input logic [15:0] a);
    if (!m_sel(a)) return 8'h00;
    case (a[2:0])
      3'd0: return m_rld[7:0];
      3'd1: return m_rld[15:8];
      3'd2: return m_cnt[7:0];
      3'd3: return m_snap;
      3'd4: return {5'b0, m_oneshot, m_irq_en, m_en};
      3'd5: return {7'b0, m_exp};
      default: return 8'h00;
    endcase
  endfunction

  // One phase-2 fall: accesses complete once LP_WAIT selected falls have been stretched.
  task automatic model_pf(input logic [15:0] a, input logic rw, input logic [7:0] d, output bit done);
    bit          sel;
    bit          expire;
    logic [15:0] old_cnt;
    sel     = m_sel(a);
    done    = sel && (m_pend >= LP_WAIT);
    m_pend  = (sel && !done) ? m_pend + 1 : 0;
    old_cnt = m_cnt;
    expire  = m_en && (m_cnt == 16'd0);
    if (m_en) m_cnt = expire ? m_rld : m_cnt - 16'd1;
    if (expire) begin
      m_exp = 1'b1;
      if (m_oneshot) m_en = 1'b0;
    end
    if (done && rw && a[2:0] == 3'd2) m_snap = old_cnt[15:8];
    if (done && !rw) begin
      case (a[2:0])
        3'd0: m_rld[7:0] = d;
        3'd1: begin
          m_rld[15:8] = d;
          m_cnt = {d, m_rld[7:0]};
          m_exp = 1'b0;
        end
        3'd4: begin
          m_en = d[0]; m_irq_en = d[1]; m_oneshot = d[2];
        end
        3'd5: if (d[0] && !expire) m_exp = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic phase(input logic [15:0] a, input logic rw, input logic [7:0] d,
                       output logic [7:0] rd, output logic rdy, output logic irq, output bit done);
    logic exp_rdy;
    @(negedge I_clock);
    I_addr = a; I_rdwr = rw; I_wr_data = d; I_phy2 = 1'b1;
    @(negedge I_clock);
    I_phy2 = 1'b0;
    #1;
    exp_rdy = !(m_sel(a) && (m_pend < LP_WAIT));
    check("sel", 16'(O_sel), 16'(m_sel(a)));
    check("ready", 16'(O_ready), 16'(exp_rdy));
    check("rd_data", 16'(O_rd_data), 16'(m_rd(a)));
    check("irq", 16'(O_irq), 16'(m_exp & m_irq_en));
    rd = O_rd_data; rdy = O_ready; irq = O_irq;
    @(posedge I_clock);
    #1;
    model_pf(a, rw, d, done);
  endtask

  task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] d, output logic [7:0] rd);
    logic rdy, irq;
    bit   done;
    int   k;
    done = 0; k = 0;
    while (!done && k < 16) begin
      phase(a, rw, d, rd, rdy, irq, done);
      k++;
      if (!m_sel(a)) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout: addr %h still stretched after %0d phases", a, k);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] rd;
    access({LP_BASE[15:3], off}, 1'b0, d, rd);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] rd;
    access({LP_BASE[15:3], off}, 1'b1, 8'h00, rd);
    check(name, 16'(rd), 16'(exp));
  endtask

  task automatic idle(input int n);
    logic [7:0] rd;
    logic rdy, irq;
    bit done;
    for (int i = 0; i < n; i++) phase(LP_IDLE, 1'b1, 8'h00, rd, rdy, irq, done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rdv;
    logic        rdy, irq;
    bit          done;
    logic [15:0] e;

    vecs[0]  = '{16'hD004, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{16'hD005, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{16'hD000, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{16'hD000, 1'b0, 8'h5A, 1'b0, 8'h00};
    vecs[4]  = '{16'hD001, 1'b0, 8'hC3, 1'b0, 8'h00};
    vecs[5]  = '{16'hD000, 1'b1, 8'h00, 1'b1, 8'h5A};
    vecs[6]  = '{16'hD001, 1'b1, 8'h00, 1'b1, 8'hC3};
    vecs[7]  = '{16'hD002, 1'b1, 8'h00, 1'b1, 8'h5A};
    vecs[8]  = '{16'hD003, 1'b1, 8'h00, 1'b1, 8'hC3};
    vecs[9]  = '{16'hD004, 1'b0, 8'hFE, 1'b0, 8'h00};
    vecs[10] = '{16'hD004, 1'b1, 8'h00, 1'b1, 8'h06};
    vecs[11] = '{16'hD006, 1'b0, 8'hFF, 1'b0, 8'h00};
    vecs[12] = '{16'hD006, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[13] = '{16'hD007, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[14] = '{16'hD002, 1'b0, 8'h11, 1'b0, 8'h00};
    vecs[15] = '{16'hD002, 1'b1, 8'h00, 1'b1, 8'h5A};
    vecs[16] = '{16'hD008, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[17] = '{16'hCFFF, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[18] = '{16'hD004, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[19] = '{16'hD004, 1'b1, 8'h00, 1'b1, 8'h00};

    I_reset = 1'b1; I_phy2 = 1'b0; I_addr = 16'h0000; I_rdwr = 1'b1; I_wr_data = 8'h00;
    model_reset();
    repeat (3) @(negedge I_clock);
    I_reset = 1'b0;

    // directed register table
    for (int i = 0; i < 20; i++) begin
      access(vecs[i].addr, vecs[i].rdwr, vecs[i].wdata, rdv);
      if (vecs[i].chk) check($sformatf("table[%0d]", i), 16'(rdv), 16'(vecs[i].exp_rd));
    end

    // periodic count: reload 3 expires at the 4th fall
    wr(3'd0, 8'h03); wr(3'd1, 8'h00); wr(3'd4, 8'h03);
    for (int i = 1; i <= 4; i++) begin
      phase(LP_IDLE, 1'b1, 8'h00, rdv, rdy, irq, done);
      if (i == 4) check("count_irq_before_expiry", 16'(irq), 16'h0);
    end
    phase(16'hD002, 1'b1, 8'h00, rdv, rdy, irq, done);
    check("count_irq_after_expiry", 16'(irq), 16'h1);
    check("count_reload", 16'(rdv), 16'h0003);
    wr(3'd4, 8'h00); wr(3'd5, 8'h01);

    // one-shot
    wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd4, 8'h07);
    idle(4);
    rd_chk("oneshot_ctrl", 3'd4, 8'h06);
    rd_chk("oneshot_cnt", 3'd2, 8'h01);
    rd_chk("oneshot_stat", 3'd5, 8'h01);
    wr(3'd4, 8'h00); wr(3'd5, 8'h01);

    // snapshot: counting continues through stretched falls of the read itself
    wr(3'd0, 8'h00); wr(3'd4, 8'h01); wr(3'd1, 8'h12);
    e = 16'h1200 - 16'(LP_WAIT);
    rd_chk("snap_cnt_lo", 3'd2, e[7:0]);
    rd_chk("snap_cnt_hi", 3'd3, e[15:8]);
    wr(3'd4, 8'h00);

    // wait states on a write to RLD_LO
    wr(3'd0, 8'h00);
    for (int i = 0; i <= LP_WAIT; i++) begin
      phase(16'hD000, 1'b0, 8'hAA, rdv, rdy, irq, done);
      check($sformatf("wait_ready[%0d]", i), 16'(rdy), 16'(i == LP_WAIT));
      check($sformatf("wait_rld_lo[%0d]", i), 16'(rdv), 16'h0000);
    end
    rd_chk("wait_rld_lo_after", 3'd0, 8'hAA);

    // W1C against continuous expiry (reload 0 wraps every fall)
    wr(3'd0, 8'h00); wr(3'd1, 8'h00); wr(3'd4, 8'h03);
    idle(2);
    wr(3'd5, 8'h01);
    rd_chk("collision_stat", 3'd5, 8'h01);
    phase(LP_IDLE, 1'b1, 8'h00, rdv, rdy, irq, done);
    check("collision_irq", 16'(irq), 16'h1);

    // reset in the middle of a CTRL write
    @(negedge I_clock);
    I_addr = 16'hD004; I_rdwr = 1'b0; I_wr_data = 8'hFF; I_phy2 = 1'b1;
    @(posedge I_clock);
    #2 I_reset = 1'b1;
    #1 I_phy2 = 1'b0;
    @(negedge I_clock);
    I_addr = 16'h0000;
    #1;
    check("reset_irq", 16'(O_irq), 16'h0);
    check("reset_ready", 16'(O_ready), 16'h1);
    check("reset_rd_data", 16'(O_rd_data), 16'h0);
    @(negedge I_clock);
    I_reset = 1'b0;
    model_reset();
    rd_chk("reset_ctrl", 3'd4, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic        rw;
      logic [7:0]  d;
      if ($urandom_range(0, 4) == 0) a = 16'($urandom);
      else a = {LP_BASE[15:3], 3'($urandom_range(0, 7))};
      rw = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (a[2:0] == 3'd0) d = d & 8'h07;
      if (a[2:0] == 3'd1 && $urandom_range(0, 3) != 0) d = 8'h00;
      access(a, rw, d, rdv);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
